ifu_fetch: RTL and testbench

//   Instruction-fetch stage upstream of IDU/BPU. Holds the architectural PC and fetches one

---
 rtl/ifu_fetch_pkg.sv | 29 ++
 rtl/ifu_npc_sel.sv | 18 +
 rtl/ifu_fetch.sv | 141 ++++++++++++++
 tb/tb_ifu_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared encodings for the instruction-fetch unit: FSM states, fault causes,
// AXI response code and reset/NOP constants.
package ifu_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR    = 3'd1,
        S_R     = 3'd2,
        S_ISSUE = 3'd3,
        S_NPC   = 3'd4,
        S_FAULT = 3'd5
    } ifu_state_e;

    typedef enum logic [1:0] {
        IFU_FAULT_NONE     = 2'd0,
        IFU_FAULT_ACCESS   = 2'd1,
        IFU_FAULT_MISALIGN = 2'd2
    } ifu_fault_e;

    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [31:0] PC_RESET_VALUE = 32'h8000_0000;
    localparam logic [31:0] INST_NOP_VALUE = 32'h0000_0013;

    // Instructions are word aligned; any low address bit set is a misaligned fetch.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_npc_sel.sv
// Next-PC selection: taken branch target or sequential pc+4 (wrapping mod 2^32),
// plus alignment check of the selected address.
module ifu_npc_sel
    import ifu_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_en,
    input  logic [31:0] dnpc,
    output logic [31:0] next_pc,
    output logic        misalign
);

    always_comb begin
        next_pc  = branch_en ? dnpc : pc + 32'd4;
        misalign = is_misaligned(next_pc);
    end

endmodule

// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch: one AXI-lite read in flight, issue to IDU, wait for BPU.
// Optional feature: define IFU_MISALIGN_CHECK_EN to fault on a misaligned next pc instead of fetching it.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_VALUE,
    parameter logic [31:0] INST_NOP = INST_NOP_VALUE
) (
    input  logic        clk,
    input  logic        rst,
    output logic        arvalid_o,
    output logic [31:0] araddr_o,
    input  logic        arready_i,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    output logic        rready_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic        npc_valid_i,
    input  logic        branch_en_i,
    input  logic [31:0] dnpc_i,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);

    ifu_state_e  state;
    ifu_fault_e  cause;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        npc_misalign;
    logic        npc_fault;
    logic        npc_load;

    ifu_npc_sel u_npc_sel (
        .pc        (pc),
        .branch_en (branch_en_i),
        .dnpc      (dnpc_i),
        .next_pc   (npc),
        .misalign  (npc_misalign)
    );

`ifdef IFU_MISALIGN_CHECK_EN
    assign npc_fault = npc_misalign;
`else
    logic unused_npc_misalign;
    assign unused_npc_misalign = npc_misalign;
    assign npc_fault = 1'b0;
`endif

    // BPU result is consumed only together with the IDU handshake or while waiting for it.
    always_comb begin
        npc_load = 1'b0;
        if (state == S_ISSUE && inst_valid_o && inst_ready_i && npc_valid_i)
            npc_load = 1'b1;
        else if (state == S_NPC && npc_valid_i)
            npc_load = 1'b1;
    end

    assign pc_o          = pc;
    assign fault_cause_o = cause;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            arvalid_o    <= 1'b0;
            araddr_o     <= RESET_PC;
            rready_o     <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_o       <= INST_NOP;
            fault_o      <= 1'b0;
            cause        <= IFU_FAULT_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    state     <= S_AR;
                    arvalid_o <= 1'b1;
                    araddr_o  <= pc;
                end
                S_AR: begin
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        state     <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid_i) begin
                        rready_o <= 1'b0;
                        if (rresp_i == AXI_RESP_OKAY) begin
                            inst_o <= rdata_i;
                            state  <= S_ISSUE;
                        end else begin
                            fault_o <= 1'b1;
                            cause   <= IFU_FAULT_ACCESS;
                            state   <= S_FAULT;
                        end
                    end
                end
                S_ISSUE: begin
                    // First cycle here is the latch cycle; valid rises on the next edge.
                    if (!inst_valid_o) begin
                        inst_valid_o <= 1'b1;
                    end else if (inst_ready_i) begin
                        inst_valid_o <= 1'b0;
                        if (!npc_valid_i)
                            state <= S_NPC;
                    end
                end
                S_NPC: begin
                end
                S_FAULT: begin
                    arvalid_o    <= 1'b0;
                    rready_o     <= 1'b0;
                    inst_valid_o <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (npc_load) begin
                pc     <= npc;
                inst_o <= INST_NOP;
                if (npc_fault) begin
                    fault_o <= 1'b1;
                    cause   <= IFU_FAULT_MISALIGN;
                    state   <= S_FAULT;
                end else begin
                    arvalid_o <= 1'b1;
                    araddr_o  <= npc;
                    state     <= S_AR;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: cycle-by-cycle vector table plus hand-written
// sequences for access fault, misaligned target and mid-transaction reset.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        arvalid_o;
    logic [31:0] araddr_o;
    logic        arready_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rready_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        npc_valid_i;
    logic        branch_en_i;
    logic [31:0] dnpc_i;
    logic        fault_o;
    logic [1:0]  fault_cause_o;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h8000_0000;

    ifu_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .arvalid_o     (arvalid_o),
        .araddr_o      (araddr_o),
        .arready_i     (arready_i),
        .rvalid_i      (rvalid_i),
        .rdata_i       (rdata_i),
        .rresp_i       (rresp_i),
        .rready_o      (rready_o),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .npc_valid_i   (npc_valid_i),
        .branch_en_i   (branch_en_i),
        .dnpc_i        (dnpc_i),
        .fault_o       (fault_o),
        .fault_cause_o (fault_cause_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        inst_ready;
        logic        npc_valid;
        logic        branch_en;
        logic [31:0] dnpc;
    } in_t;

    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic        rready;
        logic        inst_valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
        logic [1:0]  cause;
    } out_t;

    typedef struct packed {
        in_t  vin;
        out_t vexp;
    } vec_t;

    vec_t vecs[$];

    function automatic in_t vi(input logic r, input logic ar, input logic rv,
                               input logic [31:0] rd, input logic [1:0] rs,
                               input logic ir, input logic nv, input logic br,
                               input logic [31:0] dn);
        in_t v;
        v.rst = r; v.arready = ar; v.rvalid = rv; v.rdata = rd; v.rresp = rs;
        v.inst_ready = ir; v.npc_valid = nv; v.branch_en = br; v.dnpc = dn;
        return v;
    endfunction

    function automatic out_t vo(input logic av, input logic [31:0] aa, input logic rr,
                                input logic iv, input logic [31:0] in, input logic [31:0] p,
                                input logic f, input logic [1:0] c);
        out_t o;
        o.arvalid = av; o.araddr = aa; o.rready = rr; o.inst_valid = iv;
        o.inst = in; o.pc = p; o.fault = f; o.cause = c;
        return o;
    endfunction

    function automatic in_t idle_in();
        return vi(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int idx, input out_t e);
        chk({tag, ".arvalid"},    idx, {31'd0, arvalid_o},     {31'd0, e.arvalid});
        chk({tag, ".araddr"},     idx, araddr_o,               e.araddr);
        chk({tag, ".rready"},     idx, {31'd0, rready_o},      {31'd0, e.rready});
        chk({tag, ".inst_valid"}, idx, {31'd0, inst_valid_o},  {31'd0, e.inst_valid});
        chk({tag, ".inst"},       idx, inst_o,                 e.inst);
        chk({tag, ".pc"},         idx, pc_o,                   e.pc);
        chk({tag, ".fault"},      idx, {31'd0, fault_o},       {31'd0, e.fault});
        chk({tag, ".cause"},      idx, {30'd0, fault_cause_o}, {30'd0, e.cause});
    endtask

    // Drive one cycle of inputs, let the edge happen, then sample 1ns later.
    task automatic step(input in_t v);
        rst = v.rst; arready_i = v.arready; rvalid_i = v.rvalid; rdata_i = v.rdata;
        rresp_i = v.rresp; inst_ready_i = v.inst_ready; npc_valid_i = v.npc_valid;
        branch_en_i = v.branch_en; dnpc_i = v.dnpc;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input in_t v, input out_t e);
        vec_t r;
        r.vin = v; r.vexp = e;
        vecs.push_back(r);
    endtask

    int ar_seen;
    int busy_seen;

    initial begin
        rst = 1'b1; arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'h0; rresp_i = 2'b00;
        inst_ready_i = 1'b0; npc_valid_i = 1'b0; branch_en_i = 1'b0; dnpc_i = 32'h0;

        // Reset, first fetch with zero-wait slave, not-taken, taken after S_NPC, wait states, wrap.
        add(vi(1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0),         vo(0, RPC,          0, 0, NOP,          RPC,          0, 0));
        add(vi(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0),         vo(1, RPC,          0, 0, NOP,          RPC,          0, 0));
        add(vi(0, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0),         vo(0, RPC,          1, 0, NOP,          RPC,          0, 0));
        add(vi(0, 0, 1, 32'h0010_0093, 2'b00, 0, 1, 1, 32'h1234_5678), vo(0, RPC,          0, 0, 32'h0010_0093, RPC,         0, 0));
        add(vi(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0),         vo(0, RPC,          0, 1, 32'h0010_0093, RPC,         0, 0));
        add(vi(0, 0, 1, 32'hDEAD_BEEF, 2'b00, 1, 1, 0, 32'h0),         vo(1, 32'h8000_0004, 0, 0, NOP,          32'h8000_0004, 0, 0));
        add(vi(0, 1, 0, 32'h0,         2'b00, 0, 1, 1, 32'h0BAD_0000), vo(0, 32'h8000_0004, 1, 0, NOP,          32'h8000_0004, 0, 0));
        add(vi(0, 0, 1, 32'h0020_0113, 2'b00, 0, 0, 0, 32'h0),         vo(0, 32'h8000_0004, 0, 0, 32'h0020_0113, 32'h8000_0004, 0, 0));
        add(vi(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0),         vo(0, 32'h8000_0004, 0, 1, 32'h0020_0113, 32'h8000_0004, 0, 0));
        add(vi(0, 0, 0, 32'h0,         2'b00, 1, 0, 0, 32'h0),         vo(0, 32'h8000_0004, 0, 0, 32'h0020_0113, 32'h8000_0004, 0, 0));
        add(vi(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0),         vo(0, 32'h8000_0004, 0, 0, 32'h0020_0113, 32'h8000_0004, 0, 0));
        add(vi(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0),         vo(0, 32'h8000_0004, 0, 0, 32'h0020_0113, 32'h8000_0004, 0, 0));
        add(vi(0, 0, 0, 32'h0,         2'b00, 0, 1, 1, 32'h8000_0100), vo(1, 32'h8000_0100, 0, 0, NOP,          32'h8000_0100, 0, 0));
        for (int k = 0; k < 5; k++)
            add(vi(0, 0, 0, 32'h0,     2'b00, 0, 0, 0, 32'h0),         vo(1, 32'h8000_0100, 0, 0, NOP,          32'h8000_0100, 0, 0));
        add(vi(0, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0),         vo(0, 32'h8000_0100, 1, 0, NOP,          32'h8000_0100, 0, 0));
        add(vi(0, 0, 1, 32'h0030_0193, 2'b00, 0, 0, 0, 32'h0),         vo(0, 32'h8000_0100, 0, 0, 32'h0030_0193, 32'h8000_0100, 0, 0));
        add(vi(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0),         vo(0, 32'h8000_0100, 0, 1, 32'h0030_0193, 32'h8000_0100, 0, 0));
        add(vi(0, 0, 0, 32'h0,         2'b00, 1, 1, 1, 32'hFFFF_FFFC), vo(1, 32'hFFFF_FFFC, 0, 0, NOP,          32'hFFFF_FFFC, 0, 0));
        add(vi(0, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0),         vo(0, 32'hFFFF_FFFC, 1, 0, NOP,          32'hFFFF_FFFC, 0, 0));
        add(vi(0, 0, 1, 32'h0040_0213, 2'b00, 1, 0, 0, 32'h0),         vo(0, 32'hFFFF_FFFC, 0, 0, 32'h0040_0213, 32'hFFFF_FFFC, 0, 0));
        add(vi(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0),         vo(0, 32'hFFFF_FFFC, 0, 1, 32'h0040_0213, 32'hFFFF_FFFC, 0, 0));
        add(vi(0, 0, 0, 32'h0,         2'b00, 1, 1, 0, 32'h0),         vo(1, 32'h0000_0000, 0, 0, NOP,          32'h0000_0000, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].vin);
            check_outs("vec", i, vecs[i].vexp);
        end

        // Access fault on first fetch, terminal until reset.
        step(vi(1, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0));
        step(idle_in());
        step(vi(0, 1, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0));
        step(vi(0, 0, 1, 32'h1111_1111, 2'b10, 0, 0, 0, 32'h0));
        check_outs("acc_fault", 0, vo(0, RPC, 0, 0, NOP, RPC, 1, 2'd1));
        ar_seen = 0;
        busy_seen = 0;
        for (int k = 0; k < 100; k++) begin
            step(vi(0, 1, k[0], 32'h2222_2222, 2'b00, 1, 1, 0, 32'h0));
            if (arvalid_o) ar_seen++;
            if (rready_o || inst_valid_o) busy_seen++;
        end
        chk("acc_no_ar", 0, ar_seen, 0);
        chk("acc_no_hs", 0, busy_seen, 0);
        check_outs("acc_hold", 0, vo(0, RPC, 0, 0, NOP, RPC, 1, 2'd1));
        step(vi(1, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0));
        check_outs("acc_rst", 0, vo(0, RPC, 0, 0, NOP, RPC, 0, 2'd0));
        step(idle_in());
        check_outs("acc_refetch", 0, vo(1, RPC, 0, 0, NOP, RPC, 0, 2'd0));

        // Misaligned taken target.
        step(vi(0, 1, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0));
        step(vi(0, 0, 1, 32'h0010_0093, 2'b00, 0, 0, 0, 32'h0));
        step(idle_in());
        check_outs("mis_issue", 0, vo(0, RPC, 0, 1, 32'h0010_0093, RPC, 0, 2'd0));
        step(vi(0, 0, 0, 32'h0, 2'b00, 1, 1, 1, 32'h8000_0102));
`ifdef IFU_MISALIGN_CHECK_EN
        check_outs("mis_fault", 0, vo(0, RPC, 0, 0, NOP, 32'h8000_0102, 1, 2'd2));
        step(vi(0, 1, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0));
        check_outs("mis_hold", 0, vo(0, RPC, 0, 0, NOP, 32'h8000_0102, 1, 2'd2));
`else
        check_outs("mis_fetch", 0, vo(1, 32'h8000_0102, 0, 0, NOP, 32'h8000_0102, 0, 2'd0));
        step(vi(0, 1, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0));
        check_outs("mis_r", 0, vo(0, 32'h8000_0102, 1, 0, NOP, 32'h8000_0102, 0, 2'd0));
`endif

        // Reset while in S_R with a response pending; the stale response must not land.
        step(vi(1, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0));
        step(idle_in());
        step(vi(0, 1, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0));
        check_outs("rst_r_pre", 0, vo(0, RPC, 1, 0, NOP, RPC, 0, 2'd0));
        step(vi(1, 0, 1, 32'hBADC_0DE0, 2'b00, 0, 0, 0, 32'h0));
        check_outs("rst_r", 0, vo(0, RPC, 0, 0, NOP, RPC, 0, 2'd0));
        step(vi(0, 0, 1, 32'hBADC_0DE0, 2'b00, 0, 0, 0, 32'h0));
        check_outs("rst_r_stale", 0, vo(1, RPC, 0, 0, NOP, RPC, 0, 2'd0));
        step(vi(0, 1, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0));
        step(vi(0, 0, 1, 32'h0050_0293, 2'b00, 0, 0, 0, 32'h0));
        step(idle_in());
        check_outs("rst_r_after", 0, vo(0, RPC, 0, 1, 32'h0050_0293, RPC, 0, 2'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
